lcd_mode_sequencer: RTL

- Selects which of NUM_SRC pattern/filter generators drives the RGB565 LCD port.
- A debounced user button advances the mode; the switch happens only at a frame boundary and is followed by black blanking frames.
- Sits between the image generators and the TOP LCD pins in the PixelClk domain; timing comes from one shared master generator.

---
 rtl/lcd_mode_sequencer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_mode_sequencer.sv
// Purpose : selects one of NUM_SRC RGB565 pixel sources for the LCD port; a debounced
//           button (or, with LCD_MODE_AUTO_CYCLE_EN defined, a frame counter) advances
//           the mode at a frame boundary, followed by BLANK_FRAMES black frames.
// Latency : 1 PixelClk cycle from tim_*/src_rgb to LCD_* (timing and pixels aligned).
// Backpressure: none; the LCD port consumes one pixel per cycle unconditionally.
// Ports   : PixelClk/nRST (sync, active-low); btn_in raw async button;
//           tim_de/tim_hsync/tim_vsync master timing; src_rgb packed sources (k at [16k+15:16k]);
//           LCD_DE/HSYNC/VSYNC/R/G/B registered outputs; mode_idx shown source; switch_pulse.
// Option  : `define LCD_MODE_AUTO_CYCLE_EN adds an AUTO_FRAMES frame counter that advances
//           the mode on its own while idle.
module lcd_mode_sequencer #(
    parameter int          NUM_SRC         = 4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          BLANK_FRAMES    = 2,
    parameter int          VSYNC_POL       = 0,
    parameter int          HSYNC_POL       = 0,
    parameter int          AUTO_FRAMES     = 120
) (
    input  logic                   PixelClk,
    input  logic                   nRST,
    input  logic                   btn_in,
    input  logic                   tim_de,
    input  logic                   tim_hsync,
    input  logic                   tim_vsync,
    input  logic [NUM_SRC*16-1:0]  src_rgb,
    output logic                   LCD_DE,
    output logic                   LCD_HSYNC,
    output logic                   LCD_VSYNC,
    output logic [4:0]             LCD_R,
    output logic [5:0]             LCD_G,
    output logic [4:0]             LCD_B,
    output logic [2:0]             mode_idx,
    output logic                   switch_pulse
);

    localparam logic           VS_ACT     = VSYNC_POL[0];
    localparam logic           HS_ACT     = HSYNC_POL[0];
    localparam int             BW         = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [BW-1:0]  BLANK_INIT = BW'(BLANK_FRAMES);
    localparam logic [2:0]     LAST_IDX   = 3'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Button: 2-FF synchronizer, then a level filter that only accepts a
    // new level after it has been seen continuously for DEBOUNCE_CYCLES.
    // ------------------------------------------------------------------
    logic        btn_s1, btn_s2;
    logic        btn_filt, btn_filt_d;
    logic [15:0] db_cnt;
    logic        press_evt;

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            btn_s1     <= 1'b0;
            btn_s2     <= 1'b0;
            btn_filt   <= 1'b0;
            btn_filt_d <= 1'b0;
            db_cnt     <= '0;
        end else begin
            btn_s1     <= btn_in;
            btn_s2     <= btn_s1;
            btn_filt_d <= btn_filt;
            if (btn_s2 != btn_filt) begin
                if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                    btn_filt <= btn_s2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 16'd1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Rising edge of the filtered level only: a held button gives one event.
    assign press_evt = btn_filt & ~btn_filt_d;

    // ------------------------------------------------------------------
    // Timing register stage. LCD_VSYNC doubles as the registered tim_vsync;
    // vs_prev is its previous sample for edge detection.
    // ------------------------------------------------------------------
    logic        vs_prev;
    logic        frame_bound;
    logic [15:0] rgb_nxt;

    assign frame_bound = (LCD_VSYNC == VS_ACT) && (vs_prev != VS_ACT);

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            LCD_DE    <= 1'b0;
            LCD_HSYNC <= ~HS_ACT;
            LCD_VSYNC <= ~VS_ACT;
            vs_prev   <= ~VS_ACT;
            LCD_R     <= '0;
            LCD_G     <= '0;
            LCD_B     <= '0;
        end else begin
            LCD_DE    <= tim_de;
            LCD_HSYNC <= tim_hsync;
            LCD_VSYNC <= tim_vsync;
            vs_prev   <= LCD_VSYNC;
            LCD_R     <= rgb_nxt[15:11];
            LCD_G     <= rgb_nxt[10:5];
            LCD_B     <= rgb_nxt[4:0];
        end
    end

    // Source mux; an out-of-range index falls back to source 0.
    logic [2:0]  sel;
    logic [15:0] pix;

    always_comb begin
        sel = (mode_idx > LAST_IDX) ? 3'd0 : mode_idx;
        pix = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == 3'(k)) begin
                pix = src_rgb[16*k +: 16];
            end
        end
        rgb_nxt = (tim_de && (state != BLANK)) ? pix : 16'd0;
    end

    // ------------------------------------------------------------------
    // Mode advance source
    // ------------------------------------------------------------------
    logic advance;

`ifdef LCD_MODE_AUTO_CYCLE_EN
    localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES + 1) : 1;

    logic [AW-1:0] auto_cnt;
    logic          auto_evt;

    // Counts boundaries spent in IDLE; a real press restarts the count.
    assign auto_evt = (state == IDLE) && frame_bound && (auto_cnt == AW'(AUTO_FRAMES - 1));

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            auto_cnt <= '0;
        end else if (press_evt || auto_evt) begin
            auto_cnt <= '0;
        end else if ((state == IDLE) && frame_bound) begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    assign advance = press_evt | auto_evt;
`else
    logic unused_auto_frames;
    assign unused_auto_frames = AUTO_FRAMES[0];
    assign advance            = press_evt;
`endif

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    logic [2:0]    next_idx, next_idx_nxt, mode_nxt;
    logic [BW-1:0] blank_cnt, blank_nxt;
    logic          pulse_nxt;

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            state        <= IDLE;
            mode_idx     <= 3'd0;
            next_idx     <= 3'd0;
            blank_cnt    <= '0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            mode_idx     <= mode_nxt;
            next_idx     <= next_idx_nxt;
            blank_cnt    <= blank_nxt;
            switch_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_idx;
        next_idx_nxt = next_idx;
        blank_nxt    = blank_cnt;
        pulse_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // A boundary in the same cycle as the press is not used;
                // the switch waits for the following one.
                if (advance) begin
                    next_idx_nxt = (mode_idx == LAST_IDX) ? 3'd0 : mode_idx + 3'd1;
                    state_nxt    = PENDING;
                end
            end
            PENDING: begin
                if (frame_bound) begin
                    mode_nxt  = next_idx;
                    pulse_nxt = 1'b1;
                    if (BLANK_FRAMES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BLANK;
                        blank_nxt = BLANK_INIT;
                    end
                end
            end
            BLANK: begin
                if (frame_bound) begin
                    if (blank_cnt <= BW'(1)) begin
                        blank_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        blank_nxt = blank_cnt - BW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
